// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  // Legal memory read latency range; the counter is 3 bits wide.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 3;

  // The port that did not win last time; used to break ties.
  function automatic port_t other_port(input port_t p);
    return (p == INSTR) ? DATA : INSTR;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: req[0]=fetch, req[1]=data; ties go to the port not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_vld,
  output logic       grant
);
  import mem_arb_pkg::*;

  // Single requester wins outright; on a tie alternate against last_grant.
  always_comb begin
    grant_vld = |req;
    grant     = 1'b0;
    case (req)
      2'b01:   grant = 1'(INSTR);
      2'b10:   grant = 1'(DATA);
      2'b11:   grant = 1'(other_port(port_t'(last_grant)));
      default: grant = 1'(INSTR);
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports, one transaction in flight.
// Latency: memEn 1 cycle after request seen in IDLE; write done +2, read done +2+MEM_LAT.
// Backpressure: requests are levels held until done; losers simply wait for the next IDLE.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iReq,
  input  logic [WIDTH-1:0] iAddr,
  output logic             iDone,
  output logic [WIDTH-1:0] iRData,
  input  logic             dReq,
  input  logic             dWe,
  input  logic [WIDTH-1:0] dAddr,
  input  logic [WIDTH-1:0] dWData,
  output logic             dDone,
  output logic [WIDTH-1:0] dRData,
  output logic             memEn,
  output logic             memWe,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memWData,
  input  logic [WIDTH-1:0] memRData
);
  import mem_arb_pkg::*;

  generate
    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be within 1..4");
    end
  endgenerate

  // Loaded on entry to WAIT so that WAIT lasts exactly MEM_LAT cycles.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t       state_q, state_d;
  port_t            port_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  port_t            last_grant_q;

  logic             gnt_vld;
  logic             gnt_raw;
  port_t            gnt_port;
  logic             take;
  logic             capture;
  logic             finish;

  rr_arbiter2 u_rr (
    .req        ({dReq, iReq}),
    .last_grant (1'(last_grant_q)),
    .grant_vld  (gnt_vld),
    .grant      (gnt_raw)
  );

  assign gnt_port = port_t'(gnt_raw);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's id and direction; a fetch is always a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q <= INSTR;
      we_q   <= 1'b0;
    end else if (take) begin
      port_q <= gnt_port;
      we_q   <= (gnt_port == DATA) && dWe;
    end
  end

  // Memory command outputs: strobes high only in ISSUE, address/data hold between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memEn    <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
    end else begin
      memEn <= take;
      memWe <= take && (gnt_port == DATA) && dWe;
      if (take) begin
        memAddr  <= (gnt_port == DATA) ? dAddr : iAddr;
        memWData <= (gnt_port == DATA) ? dWData : '0;
      end
    end
  end

  // Read latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= LAT_LOAD;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Read data lands only in the winner's register; stores never reach WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iRData <= '0;
      dRData <= '0;
    end else if (capture) begin
      if (port_q == INSTR) iRData <= memRData;
      else                 dRData <= memRData;
    end
  end

  // Done pulses are high for the single RESP cycle of the winning port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iDone <= 1'b0;
      dDone <= 1'b0;
    end else begin
      iDone <= (state_d == RESP) && (port_q == INSTR);
      dDone <= (state_d == RESP) && (port_q == DATA);
    end
  end

  // Remember who was served so the next tie goes the other way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant_q <= INSTR;
    else if (finish) last_grant_q <= port_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [31:0] J = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWData, memRData;

  logic        o1_iDone, o1_dDone, o1_memEn, o1_memWe;
  logic [31:0] o1_iRData, o1_dRData, o1_memAddr, o1_memWData;
  logic        o3_iDone, o3_dDone, o3_memEn, o3_memWe;
  logic [31:0] o3_iRData, o3_dRData, o3_memAddr, o3_memWData;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iDone(o1_iDone), .iRData(o1_iRData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
    .dDone(o1_dDone), .dRData(o1_dRData),
    .memEn(o1_memEn), .memWe(o1_memWe), .memAddr(o1_memAddr),
    .memWData(o1_memWData), .memRData(memRData)
  );

  mem_arbiter #(.WIDTH(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iDone(o3_iDone), .iRData(o3_iRData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
    .dDone(o3_dDone), .dRData(o3_dRData),
    .memEn(o3_memEn), .memWe(o3_memWe), .memAddr(o3_memAddr),
    .memWData(o3_memWData), .memRData(memRData)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_idone;
    logic        e_ddone;
    logic [31:0] e_ir;
    logic [31:0] e_dr;
  } vec_t;

  vec_t vec [15];

  function automatic vec_t mk(
    input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwe,
    input logic [31:0] daddr, input logic [31:0] dwdata, input logic [31:0] rdata,
    input logic e_en, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic e_idone, input logic e_ddone, input logic [31:0] e_ir, input logic [31:0] e_dr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.rdata = rdata;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_idone = e_idone; v.e_ddone = e_ddone; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".d1_bits"}, {28'd0, o1_memEn, o1_memWe, o1_iDone, o1_dDone}, 32'd0);
    chk({tag, ".d1_addr"}, o1_memAddr, 32'd0);
    chk({tag, ".d1_wdata"}, o1_memWData, 32'd0);
    chk({tag, ".d1_irdata"}, o1_iRData, 32'd0);
    chk({tag, ".d1_drdata"}, o1_dRData, 32'd0);
    chk({tag, ".d3_bits"}, {28'd0, o3_memEn, o3_memWe, o3_iDone, o3_dDone}, 32'd0);
    chk({tag, ".d3_addr"}, o3_memAddr, 32'd0);
    chk({tag, ".d3_wdata"}, o3_memWData, 32'd0);
    chk({tag, ".d3_irdata"}, o3_iRData, 32'd0);
    chk({tag, ".d3_drdata"}, o3_dRData, 32'd0);
  endtask

  task automatic idle_inputs();
    iReq = 1'b0; iAddr = 32'd0; dReq = 1'b0; dWe = 1'b0;
    dAddr = 32'd0; dWData = 32'd0; memRData = J;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] a1 [8];
  logic [31:0] a3 [8];
  int n1, n3;
  int seen;
  int lat;

  initial begin
    // MEM_LAT=1 cycle table: fetch, store, then a tie after a data grant.
    //              ireq iaddr      dreq dwe daddr     dwdata      rdata           en we addr       wdata      id dd ir              dr
    vec[0]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,    J,             1, 0, 32'h10, 32'h0,    0, 0, 32'h0,        32'h0);
    vec[1]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,    J,             0, 0, 32'h10, 32'h0,    0, 0, 32'h0,        32'h0);
    vec[2]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF,  0, 0, 32'h10, 32'h0,    1, 0, 32'hDEADBEEF, 32'h0);
    vec[3]  = mk(0, 32'h10, 0, 0, 32'h0,  32'h0,    J,             0, 0, 32'h10, 32'h0,    0, 0, 32'hDEADBEEF, 32'h0);
    vec[4]  = mk(0, 32'h0,  1, 1, 32'h40, 32'h1234, J,             1, 1, 32'h40, 32'h1234, 0, 0, 32'hDEADBEEF, 32'h0);
    vec[5]  = mk(0, 32'h0,  1, 1, 32'h40, 32'h1234, J,             0, 0, 32'h40, 32'h1234, 0, 1, 32'hDEADBEEF, 32'h0);
    vec[6]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    J,             0, 0, 32'h40, 32'h0,    0, 0, 32'hDEADBEEF, 32'h0);
    vec[7]  = mk(1, 32'h20, 1, 0, 32'h80, 32'h0,    J,             1, 0, 32'h20, 32'h0,    0, 0, 32'hDEADBEEF, 32'h0);
    vec[8]  = mk(1, 32'h20, 1, 0, 32'h80, 32'h0,    J,             0, 0, 32'h20, 32'h0,    0, 0, 32'hDEADBEEF, 32'h0);
    vec[9]  = mk(1, 32'h20, 1, 0, 32'h80, 32'h0,    32'h11112222,  0, 0, 32'h20, 32'h0,    1, 0, 32'h11112222, 32'h0);
    vec[10] = mk(0, 32'h20, 1, 0, 32'h80, 32'h0,    J,             0, 0, 32'h20, 32'h0,    0, 0, 32'h11112222, 32'h0);
    vec[11] = mk(0, 32'h0,  1, 0, 32'h80, 32'h0,    J,             1, 0, 32'h80, 32'h0,    0, 0, 32'h11112222, 32'h0);
    vec[12] = mk(0, 32'h0,  1, 0, 32'h80, 32'h0,    J,             0, 0, 32'h80, 32'h0,    0, 0, 32'h11112222, 32'h0);
    vec[13] = mk(0, 32'h0,  1, 0, 32'h80, 32'h0,    32'h33334444,  0, 0, 32'h80, 32'h0,    0, 1, 32'h11112222, 32'h33334444);
    vec[14] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,    J,             0, 0, 32'h80, 32'h0,    0, 0, 32'h11112222, 32'h33334444);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_init");

    @(negedge clk);
    reset = 1'b0;

    // Table-driven sequence on the MEM_LAT=1 instance.
    for (int i = 0; i < 15; i++) begin
      iReq = vec[i].ireq; iAddr = vec[i].iaddr; dReq = vec[i].dreq; dWe = vec[i].dwe;
      dAddr = vec[i].daddr; dWData = vec[i].dwdata; memRData = vec[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d.memEn", i), {31'd0, o1_memEn}, {31'd0, vec[i].e_en});
      chk($sformatf("row%0d.memWe", i), {31'd0, o1_memWe}, {31'd0, vec[i].e_we});
      chk($sformatf("row%0d.memAddr", i), o1_memAddr, vec[i].e_addr);
      if (vec[i].e_we) chk($sformatf("row%0d.memWData", i), o1_memWData, vec[i].e_wdata);
      chk($sformatf("row%0d.iDone", i), {31'd0, o1_iDone}, {31'd0, vec[i].e_idone});
      chk($sformatf("row%0d.dDone", i), {31'd0, o1_dDone}, {31'd0, vec[i].e_ddone});
      chk($sformatf("row%0d.iRData", i), o1_iRData, vec[i].e_ir);
      chk($sformatf("row%0d.dRData", i), o1_dRData, vec[i].e_dr);
    end

    // Both ports request continuously out of reset: D, I, D, I on both instances.
    @(negedge clk);
    reset = 1'b1;
    iReq = 1'b1; iAddr = 32'h100; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h200;
    dWData = 32'd0; memRData = 32'hA5A50000;
    @(negedge clk);
    reset = 1'b0;
    n1 = 0; n3 = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o1_memEn && n1 < 8) begin a1[n1] = o1_memAddr; n1++; end
      if (o3_memEn && n3 < 8) begin a3[n3] = o3_memAddr; n3++; end
    end
    chk("rr.d1_count_ge4", {31'd0, (n1 >= 4)}, 32'd1);
    chk("rr.d3_count_ge4", {31'd0, (n3 >= 4)}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < n1) chk($sformatf("rr.d1_addr%0d", k), a1[k], (k % 2 == 0) ? 32'h200 : 32'h100);
      if (k < n3) chk($sformatf("rr.d3_addr%0d", k), a3[k], (k % 2 == 0) ? 32'h200 : 32'h100);
    end

    // Reset asserted between clock edges clears every output at once.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("reset_mid");
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    // MEM_LAT=3 load; memory data valid only in the last WAIT cycle.
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80; memRData = J;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      case (e)
        0: begin
          chk("lat3.e0_memEn", {31'd0, o3_memEn}, 32'd1);
          chk("lat3.e0_memWe", {31'd0, o3_memWe}, 32'd0);
          chk("lat3.e0_memAddr", o3_memAddr, 32'h80);
        end
        1, 2, 3: begin
          chk($sformatf("lat3.e%0d_dDone", e), {31'd0, o3_dDone}, 32'd0);
          chk($sformatf("lat3.e%0d_memEn", e), {31'd0, o3_memEn}, 32'd0);
          if (e == 3) memRData = 32'hCAFE0001;
        end
        4: begin
          chk("lat3.e4_dDone", {31'd0, o3_dDone}, 32'd1);
          chk("lat3.e4_dRData", o3_dRData, 32'hCAFE0001);
          chk("lat3.e4_iRData", o3_iRData, 32'd0);
          memRData = J;
          dReq = 1'b0;
        end
        default: begin
          chk("lat3.e5_dDone", {31'd0, o3_dDone}, 32'd0);
          chk("lat3.e5_dRData", o3_dRData, 32'hCAFE0001);
        end
      endcase
    end

    // Reset while a MEM_LAT=3 fetch sits in WAIT: it must never report done.
    do_reset();
    iReq = 1'b1; iAddr = 32'h44; memRData = J;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    iReq = 1'b0;
    #1;
    chk("rstwait.d3_bits", {28'd0, o3_memEn, o3_memWe, o3_iDone, o3_dDone}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (o3_iDone || o3_dDone) seen++;
    end
    chk("rstwait.no_done", seen, 32'd0);

    // A fresh fetch after the aborted one completes with the right data and latency.
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h48; memRData = 32'h600DF00D;
    lat = -1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (o3_iDone) begin lat = n; break; end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL refetch.timeout: no iDone within 15 cycles, expected one at edge 4");
    end else begin
      chk("refetch.latency", lat, 32'd4);
      chk("refetch.iRData", o3_iRData, 32'h600DF00D);
    end
    iReq = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
